// File: rtl/conv_row_accum_requant_if.sv
// Row-sum input stream and requantized pixel output stream of conv_row_accum_requant.
// The master drives row sums and consumes pixels; the slave is the accumulator.
interface conv_row_accum_requant_if #(
  parameter int IN_W   = 38,
  parameter int BIAS_W = 32,
  parameter int OUT_W  = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic [BIAS_W-1:0]   bias;
  logic [4:0]          shift;
  logic                relu_en;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_sat;

  modport master (
    output in_valid, in_data, bias, shift, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, bias, shift, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_row_accum_requant.sv
// Accumulates NUM_TERMS adder-tree row sums plus bias into one pixel, then applies
// optional ReLU, round-half-up arithmetic shift and int8 saturation behind valid/ready.
module conv_row_accum_requant #(
  parameter int IN_W      = 38,
  parameter int BIAS_W    = 32,
  parameter int ACC_W     = 44,
  parameter int NUM_TERMS = 3,
  parameter int OUT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  conv_row_accum_requant_if.slave  bus
);
  localparam int                  CNT_W    = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(NUM_TERMS - 1);
  localparam logic signed [ACC_W:0] ONE_S  = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] Q_MAX  = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] Q_MIN  = (ACC_W+1)'(-(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0]    OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]    OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    is_last_s, in_ready_s, in_fire_s, out_fire_s;
  logic signed [ACC_W-1:0] base_s, acc_next_s;
  logic signed [ACC_W:0]   v_s, rnd_s, r_s;
  logic [OUT_W-1:0]        q_data_s;
  logic                    q_sat_s;

  // Only the final term of a pixel can be blocked by an unconsumed result.
  assign is_last_s  = (cnt_q == LAST_CNT);
  assign in_ready_s = !(out_valid_q && !bus.out_ready && is_last_s);
  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // Accumulate, then ReLU, round-half-up shift and saturate the candidate pixel.
  always_comb begin
    if (cnt_q == '0) begin
      base_s = {{(ACC_W-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias};
    end else begin
      base_s = acc_q;
    end
    acc_next_s = base_s + {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    if (bus.relu_en && acc_next_s[ACC_W-1]) begin
      v_s = '0;
    end else begin
      v_s = {acc_next_s[ACC_W-1], acc_next_s};
    end
    if (bus.shift != 5'd0) begin
      rnd_s = ONE_S <<< (bus.shift - 5'd1);
    end else begin
      rnd_s = '0;
    end
    r_s = (v_s + rnd_s) >>> bus.shift;
    if (r_s > Q_MAX) begin
      q_data_s = OUT_MAX;
      q_sat_s  = 1'b1;
    end else if (r_s < Q_MIN) begin
      q_data_s = OUT_MIN;
      q_sat_s  = 1'b1;
    end else begin
      q_data_s = r_s[OUT_W-1:0];
      q_sat_s  = 1'b0;
    end
  end

  // Next-state: clear aborts the pixel and drops any simultaneous input transfer.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (clear) begin
      cnt_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_fire_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (in_fire_s && is_last_s) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = q_data_s;
        out_sat_d   = q_sat_s;
      end else if (in_fire_s) begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_next_s;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_conv_row_accum_requant.sv
// Scoreboard bench: the driver models each pixel arithmetically and queues the
// expected result; a negedge monitor compares every accepted output pixel.
module tb_conv_row_accum_requant;
  localparam int IN_W = 38, BIAS_W = 32, ACC_W = 44, NT = 3, OUT_W = 8;

  typedef struct { longint data; bit sat; } exp_t;

  logic clk, rst_n, clear;
  conv_row_accum_requant_if #(.IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

  conv_row_accum_requant #(
    .IN_W(IN_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .NUM_TERMS(NT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     pix_seen = 0;
  exp_t   exp_q[$];
  longint m_sum;
  int     m_idx = 0;
  bit     rand_rdy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t requant(input longint s, input int sh, input bit relu);
    exp_t   e;
    longint v, r;
    v = (relu && s < 0) ? 64'sd0 : s;
    r = v + ((sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1)));
    r = r >>> sh;
    if (r > 127) begin
      e.data = 127; e.sat = 1'b1;
    end else if (r < -128) begin
      e.data = -128; e.sat = 1'b1;
    end else begin
      e.data = r; e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic model_accept(input longint d, input longint b, input int sh, input bit relu);
    if (m_idx == 0) m_sum = b + d;
    else m_sum = m_sum + d;
    m_idx++;
    if (m_idx == NT) begin
      exp_q.push_back(requant(m_sum, sh, relu));
      m_idx = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Present one term and hold it until accepted (bounded); in_valid is left high.
  task automatic send_term(input longint d, input longint b, input int sh, input bit relu,
                           output bit stalled);
    int waited;
    bit ok;
    waited = 0; ok = 0; stalled = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(d);
    bus.bias     = BIAS_W'(b);
    bus.shift    = 5'(sh);
    bus.relu_en  = relu;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else begin
        stalled = 1; waited++;
        tick();
      end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    else begin
      tick();
      model_accept(d, b, sh, relu);
    end
  endtask

  task automatic send_pixel(input longint t0, input longint t1, input longint t2,
                            input longint b, input int sh, input bit relu);
    bit st;
    send_term(t0, b, sh, relu, st);
    send_term(t1, b, sh, relu, st);
    send_term(t2, b, sh, relu, st);
    idle();
  endtask

  function automatic longint rand_term();
    longint x;
    case ($urandom_range(0, 2))
      0: x = longint'($urandom_range(0, 2000)) - 64'sd1000;
      1: x = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
      default: begin
        x = longint'({$urandom, $urandom});
        x = (x <<< 26) >>> 26;
      end
    endcase
    return x;
  endfunction

  // Scoreboard monitor: one pop per output transfer.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pixel", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pixel_data", longint'($signed(bus.out_data)), e.data);
        check("pixel_sat", longint'(bus.out_sat), longint'(e.sat));
        pix_seen++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    bit     st, any_st;
    int     seen0, waited;
    exp_t   exp_a;
    longint t3b;

    rst_n = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.bias = '0; bus.shift = '0;
    bus.relu_en = 1'b0; bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_sat", longint'(bus.out_sat), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", longint'(bus.in_ready), 1);

    // Basic pixel with latency check.
    send_term(100, 10, 2, 0, st);
    send_term(200, 10, 2, 0, st);
    check("basic_not_early", longint'(bus.out_valid), 0);
    send_term(-50, 10, 2, 0, st);
    idle();
    check("basic_valid", longint'(bus.out_valid), 1);
    check("basic_data", longint'($signed(bus.out_data)), 65);
    tick();
    check("basic_valid_drop", longint'(bus.out_valid), 0);

    // Rounding, saturation, ReLU and wide-sum boundaries.
    send_pixel(-5, 0, 0, 0, 2, 0);
    send_pixel(6, 0, 0, 0, 2, 0);
    send_pixel(7, 0, 0, 0, 0, 0);
    send_pixel(1000, 1000, 1000, 0, 0, 0);
    send_pixel(-1000, -1000, -1000, 0, 0, 0);
    send_pixel(-40, 0, 0, 0, 0, 1);
    send_pixel(64'sd1 <<< 36, 64'sd1 <<< 36, 64'sd1 <<< 36, 64'sd2147483647, 0, 0);
    send_pixel(-(64'sd1 <<< 37), -(64'sd1 <<< 37), -(64'sd1 <<< 37), -64'sd2147483648, 31, 0);
    tick();

    // Backpressure: pixel A held, terms 1 and 2 flow, term 3 stalls.
    bus.out_ready = 1'b0;
    send_pixel(30, 40, 50, 5, 1, 0);
    exp_a = exp_q[0];
    any_st = 0;
    send_term(1, 0, 0, 0, st); any_st |= st;
    send_term(2, 0, 0, 0, st); any_st |= st;
    check("bp_first_terms_stall", longint'(any_st), 0);
    t3b = 3;
    bus.in_data = IN_W'(t3b);
    @(negedge clk);
    check("bp_in_ready_low", longint'(bus.in_ready), 0);
    check("bp_hold_data", longint'($signed(bus.out_data)), exp_a.data);
    tick();
    check("bp_hold_data2", longint'($signed(bus.out_data)), exp_a.data);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_high", longint'(bus.in_ready), 1);
    tick();
    model_accept(t3b, 0, 0, 0);
    bus.out_ready = 1'b0;
    idle();
    check("bp_valid_kept", longint'(bus.out_valid), 1);
    check("bp_pixel_b", longint'($signed(bus.out_data)), exp_q[0].data);
    tick();
    bus.out_ready = 1'b1;
    tick();

    // Back-to-back: 9 continuous terms, in_ready must never drop.
    seen0 = pix_seen; any_st = 0;
    for (int i = 0; i < 9; i++) begin
      send_term(rand_term(), int'($urandom), $urandom_range(0, 31), 1'($urandom_range(0, 1)), st);
      any_st |= st;
    end
    idle();
    check("b2b_valid_last", longint'(bus.out_valid), 1);
    tick();
    check("b2b_no_stall", longint'(any_st), 0);
    check("b2b_pixels", longint'(pix_seen - seen0), 3);

    // Clear after 2 terms; a transfer offered during clear is dropped.
    send_term(77, 9, 0, 0, st);
    send_term(88, 9, 0, 0, st);
    bus.in_data = IN_W'(64'sd999);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    m_idx = 0;
    check("clear_valid", longint'(bus.out_valid), 0);
    send_term(4, 0, 0, 0, st);
    send_term(5, 0, 0, 0, st);
    send_term(6, 0, 0, 0, st);
    idle();
    check("clear_result", longint'($signed(bus.out_data)), 15);
    tick();

    // Asynchronous reset while a result is held and a pixel is partial.
    bus.out_ready = 1'b0;
    send_pixel(11, 12, 13, 0, 0, 0);
    send_term(99, 0, 0, 0, st);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", longint'(bus.out_valid), 0);
    check("arst_data", longint'(bus.out_data), 0);
    exp_q.delete();
    m_idx = 0;
    tick(); tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    send_pixel(-20, 7, 8, 100, 3, 0);
    check("arst_fresh", longint'($signed(bus.out_data)), 12);

    // Randomized traffic with random backpressure.
    tick();
    rand_rdy = 1;
    for (int p = 0; p < 40; p++) begin
      for (int t = 0; t < NT; t++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle();
          tick();
        end
        send_term(rand_term(), longint'(int'($urandom)), $urandom_range(0, 31),
                  1'($urandom_range(0, 1)), st);
      end
    end
    idle();
    rand_rdy = 0;
    tick(); tick();
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() > 0 && waited < 100) begin
      tick();
      waited++;
    end
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
